// File: rtl/dma_copy_engine.sv
// Single-channel word-copy DMA engine. Stalls the CPU and owns the shared bus
// while a transfer runs; otherwise passes the CPU bus cycles straight through.
module dma_copy_engine #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   read,
    input  logic                   write,
    input  logic                   src_cs,
    input  logic                   dst_cs,
    input  logic                   count_cs,
    input  logic                   control_cs,
    input  logic [31:0]            data_in,
    output logic [31:0]            data_out,
    output logic                   data_out_valid,
    input  logic [31:2]            cpu_address,
    input  logic [31:0]            cpu_data_out,
    input  logic [3:0]             cpu_data_strobes,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    output logic [31:2]            bus_address,
    output logic [31:0]            bus_data_out,
    output logic [3:0]             bus_data_strobes,
    output logic                   bus_read,
    output logic                   bus_write,
    input  logic [31:0]            bus_data_in,
    output logic                   cpu_hold
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        READ,
        CAPTURE,
        WRITE
    } state_t;

    state_t                 state;
    logic [31:2]            src_reg;
    logic [31:2]            dst_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [31:0]            buffer;
    logic                   done;
    logic                   aborted;
    logic                   abort_pending;

    logic                   busy;
    logic                   control_write;
    logic                   start_req;
    logic                   abort_req;
    logic [COUNT_WIDTH-1:0] count_next;

    assign busy          = (state != IDLE);
    assign cpu_hold      = busy;
    assign control_write = write & control_cs;
    assign start_req     = control_write & data_in[0];
    assign abort_req     = control_write & data_in[1];
    assign count_next    = count_reg - COUNT_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            count_reg     <= '0;
            buffer        <= '0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            abort_pending <= 1'b0;
        end else begin
            // An abort only registers intent; it is acted on when a word finishes.
            if (busy && abort_req) begin
                abort_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (write && src_cs) begin
                        src_reg <= data_in[31:2];
                    end
                    if (write && dst_cs) begin
                        dst_reg <= data_in[31:2];
                    end
                    if (write && count_cs) begin
                        count_reg <= data_in[COUNT_WIDTH-1:0];
                    end
                    if (start_req) begin
                        aborted <= 1'b0;
                        if (count_reg != '0) begin
                            state         <= REQUEST;
                            done          <= 1'b0;
                            abort_pending <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                REQUEST: begin
                    state <= READ;
                end

                READ: begin
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    buffer <= bus_data_in;
                    state  <= WRITE;
                end

                WRITE: begin
                    src_reg   <= src_reg + 30'd1;
                    dst_reg   <= dst_reg + 30'd1;
                    count_reg <= count_next;
                    // Natural completion wins over an abort landing on the last word.
                    if (count_next == '0) begin
                        state         <= IDLE;
                        done          <= 1'b1;
                        abort_pending <= 1'b0;
                    end else if (abort_pending || abort_req) begin
                        state         <= IDLE;
                        aborted       <= 1'b1;
                        abort_pending <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_out_valid = read & (src_cs | dst_cs | count_cs | control_cs);
        data_out       = '0;
        if (read) begin
            if (control_cs) begin
                data_out = {29'b0, aborted, done, busy};
            end else if (src_cs) begin
                data_out = {src_reg, 2'b00};
            end else if (dst_cs) begin
                data_out = {dst_reg, 2'b00};
            end else if (count_cs) begin
                data_out = {{(32-COUNT_WIDTH){1'b0}}, count_reg};
            end
        end
    end

    always_comb begin
        bus_address      = cpu_address;
        bus_data_out     = cpu_data_out;
        bus_data_strobes = cpu_data_strobes;
        bus_read         = cpu_read;
        bus_write        = cpu_write;
        if (cpu_hold) begin
            bus_address      = (state == WRITE) ? dst_reg : src_reg;
            bus_data_out     = buffer;
            bus_data_strobes = ((state == READ) || (state == WRITE)) ? 4'b1111 : 4'b0000;
            bus_read         = (state == READ);
            bus_write        = (state == WRITE);
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: a scoreboard of expected engine bus
// operations is filled when a transfer starts and drained by a bus monitor.
module tb_dma_copy_engine;

    localparam logic [3:0] SEL_SRC   = 4'b0001;
    localparam logic [3:0] SEL_DST   = 4'b0010;
    localparam logic [3:0] SEL_COUNT = 4'b0100;
    localparam logic [3:0] SEL_CTL   = 4'b1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        src_cs = 1'b0;
    logic        dst_cs = 1'b0;
    logic        count_cs = 1'b0;
    logic        control_cs = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic [31:2] cpu_address = '0;
    logic [31:0] cpu_data_out = '0;
    logic [3:0]  cpu_data_strobes = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:2] bus_address;
    logic [31:0] bus_data_out;
    logic [3:0]  bus_data_strobes;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_data_in;
    logic        cpu_hold;

    typedef struct {
        logic        is_write;
        logic [29:0] addr;
        logic [31:0] data;
        int          cycle;
    } bus_op_t;

    bus_op_t exp_q[$];
    int tests = 0;
    int failures = 0;
    int edge_count = 0;
    int last_edge = 0;
    int start_edge = 0;
    int hold_cycles = 0;
    int first_hold_label = 0;
    int writes_seen = 0;

    dma_copy_engine #(.COUNT_WIDTH(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .read             (read),
        .write            (write),
        .src_cs           (src_cs),
        .dst_cs           (dst_cs),
        .count_cs         (count_cs),
        .control_cs       (control_cs),
        .data_in          (data_in),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .cpu_address      (cpu_address),
        .cpu_data_out     (cpu_data_out),
        .cpu_data_strobes (cpu_data_strobes),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .bus_address      (bus_address),
        .bus_data_out     (bus_data_out),
        .bus_data_strobes (bus_data_strobes),
        .bus_read         (bus_read),
        .bus_write        (bus_write),
        .bus_data_in      (bus_data_in),
        .cpu_hold         (cpu_hold)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_count = edge_count + 1;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus_data_in = mem_word(bus_address);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Engine-side bus monitor: counts hold cycles and drains the scoreboard.
    always @(negedge clock) begin
        bus_op_t op;
        if (cpu_hold) begin
            if (hold_cycles == 0) first_hold_label = edge_count + 1;
            hold_cycles++;
            if (bus_write) writes_seen++;
            if (bus_read || bus_write) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected bus op", {30'b0, bus_write, bus_read}, 32'h0);
                end else begin
                    op = exp_q.pop_front();
                    checkOutput("op kind", {30'b0, bus_write, bus_read}, op.is_write ? 32'd2 : 32'd1);
                    checkOutput("op address", {2'b0, bus_address}, {2'b0, op.addr});
                    checkOutput("op cycle", edge_count + 1, op.cycle);
                    checkOutput("op strobes", {28'b0, bus_data_strobes}, 32'hF);
                    if (op.is_write) checkOutput("write data", bus_data_out, op.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] value);
        write = 1'b1;
        {control_cs, count_cs, dst_cs, src_cs} = sel;
        data_in = value;
        @(posedge clock);
        #1;
        last_edge = edge_count;
        write = 1'b0;
        {control_cs, count_cs, dst_cs, src_cs} = 4'b0;
        data_in = '0;
    endtask

    task automatic readReg(input string tag, input logic [3:0] sel, input logic [31:0] expected);
        read = 1'b1;
        {control_cs, count_cs, dst_cs, src_cs} = sel;
        #1;
        checkOutput({tag, " valid"}, {31'b0, data_out_valid}, 32'h1);
        checkOutput(tag, data_out, expected);
        read = 1'b0;
        {control_cs, count_cs, dst_cs, src_cs} = 4'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic checkPassthrough(input string tag);
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        a = $urandom;
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        cpu_address = a[31:2];
        cpu_data_out = d;
        cpu_data_strobes = s;
        cpu_read = 1'b1;
        cpu_write = 1'b0;
        #1;
        checkOutput({tag, " address"}, {bus_address, 2'b00}, {a[31:2], 2'b00});
        checkOutput({tag, " data"}, bus_data_out, d);
        checkOutput({tag, " strobes"}, {28'b0, bus_data_strobes}, {28'b0, s});
        checkOutput({tag, " rd/wr"}, {30'b0, bus_read, bus_write}, 32'h2);
        cpu_read = 1'b0;
        cpu_write = 1'b1;
        #1;
        checkOutput({tag, " rd/wr swap"}, {30'b0, bus_read, bus_write}, 32'h1);
        cpu_write = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic pushCopy(input logic [29:0] s, input logic [29:0] d, input int n);
        bus_op_t op;
        for (int i = 0; i < n; i++) begin
            op.is_write = 1'b0;
            op.addr = s + 30'(i);
            op.data = '0;
            op.cycle = start_edge + 2 + 3 * i;
            exp_q.push_back(op);
            op.is_write = 1'b1;
            op.addr = d + 30'(i);
            op.data = mem_word(s + 30'(i));
            op.cycle = start_edge + 4 + 3 * i;
            exp_q.push_back(op);
        end
    endtask

    task automatic startTransfer();
        hold_cycles = 0;
        writes_seen = 0;
        applyStimulus(SEL_CTL, 32'h1);
        start_edge = last_edge;
    endtask

    task automatic skipTo(input int target);
        while (edge_count < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic waitIdle();
        bit idle_seen = 1'b0;
        for (int k = 0; k < 300 && !idle_seen; k++) begin
            @(negedge clock);
            if (!cpu_hold) idle_seen = 1'b1;
        end
        if (!idle_seen) checkOutput("idle timeout", 32'h0, 32'h1);
        @(posedge clock);
        #1;
    endtask

    task automatic checkCopyDone(input string tag, input int n);
        waitIdle();
        checkOutput({tag, " hold cycles"}, hold_cycles, 1 + 3 * n);
        checkOutput({tag, " first hold"}, first_hold_label, start_edge + 1);
        checkOutput({tag, " scoreboard empty"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        checkOutput("hold in reset", {31'b0, cpu_hold}, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        readReg("reset control", SEL_CTL, 32'h0);
        readReg("reset src", SEL_SRC, 32'h0);
        readReg("reset count", SEL_COUNT, 32'h0);
        checkPassthrough("idle pass");
        src_cs = 1'b1;
        #1;
        checkOutput("no read strobe valid", {31'b0, data_out_valid}, 32'h0);
        checkOutput("no read strobe data", data_out, 32'h0);
        src_cs = 1'b0;
        @(posedge clock);
        #1;

        // Basic two-word copy
        applyStimulus(SEL_SRC, 32'h0000_0100);
        applyStimulus(SEL_DST, 32'h0100_0000);
        applyStimulus(SEL_COUNT, 32'd2);
        startTransfer();
        pushCopy(30'h40, 30'h40_0000, 2);
        checkCopyDone("copy", 2);
        readReg("copy control", SEL_CTL, 32'h2);
        readReg("copy src after", SEL_SRC, 32'h0000_0108);
        readReg("copy count after", SEL_COUNT, 32'h0);

        // Abort written during the second READ
        applyStimulus(SEL_SRC, 32'h0000_1000);
        applyStimulus(SEL_DST, 32'h0000_2000);
        applyStimulus(SEL_COUNT, 32'd5);
        startTransfer();
        pushCopy(30'h400, 30'h800, 2);
        skipTo(start_edge + 4);
        applyStimulus(SEL_CTL, 32'h2);
        checkCopyDone("abort", 2);
        checkOutput("abort writes", writes_seen, 2);
        readReg("abort control", SEL_CTL, 32'h4);
        readReg("abort count", SEL_COUNT, 32'd3);

        // Zero-count start
        applyStimulus(SEL_COUNT, 32'd0);
        hold_cycles = 0;
        applyStimulus(SEL_CTL, 32'h1);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        checkOutput("zero hold cycles", hold_cycles, 0);
        readReg("zero control", SEL_CTL, 32'h2);

        // Source address wrap
        applyStimulus(SEL_SRC, 32'hFFFF_FFFC);
        applyStimulus(SEL_DST, 32'h0000_3000);
        applyStimulus(SEL_COUNT, 32'd2);
        startTransfer();
        pushCopy(30'h3FFF_FFFF, 30'hC00, 2);
        checkCopyDone("wrap", 2);
        readReg("wrap src after", SEL_SRC, 32'h0000_0004);

        // Register write and second start while busy
        applyStimulus(SEL_SRC, 32'h0000_0300);
        applyStimulus(SEL_DST, 32'h0000_4000);
        applyStimulus(SEL_COUNT, 32'd3);
        startTransfer();
        pushCopy(30'hC0, 30'h1000, 3);
        applyStimulus(SEL_SRC, 32'h0000_0200);
        applyStimulus(SEL_CTL, 32'h1);
        checkCopyDone("busy", 3);
        readReg("busy src after", SEL_SRC, 32'h0000_030C);
        readReg("busy control", SEL_CTL, 32'h2);

        // Reset during CAPTURE of the first word, with a competing COUNT write
        applyStimulus(SEL_SRC, 32'h0000_0400);
        applyStimulus(SEL_DST, 32'h0000_0800);
        applyStimulus(SEL_COUNT, 32'd2);
        startTransfer();
        pushCopy(30'h100, 30'h200, 1);
        void'(exp_q.pop_back());
        skipTo(start_edge + 2);
        reset = 1'b1;
        applyStimulus(SEL_COUNT, 32'd7);
        checkOutput("reset hold drop", {31'b0, cpu_hold}, 32'h0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkOutput("reset writes", writes_seen, 0);
        checkOutput("reset scoreboard empty", exp_q.size(), 0);
        readReg("reset2 control", SEL_CTL, 32'h0);
        readReg("reset2 src", SEL_SRC, 32'h0);
        readReg("reset2 dst", SEL_DST, 32'h0);
        readReg("reset2 count", SEL_COUNT, 32'h0);
        checkPassthrough("final pass");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the word-count register.
REQ-002 SHALL have ports `clock` (in, 1, cpu_clock domain) and `reset` (in, 1); reset is synchronous and active-high, and there is one clock.
REQ-003 SHALL have port `read` (in, 1), the CPU register read strobe.
REQ-004 SHALL have port `write` (in, 1), the CPU register write strobe.
REQ-005 SHALL have ports `src_cs`, `dst_cs`, `count_cs` and `control_cs` (in, 1 each), the register selects from the board decoder.
REQ-006 SHALL have port `data_in` (in, 32), CPU write data for the registers.
REQ-007 SHALL have ports `data_out` (out, 32) and `data_out_valid` (out, 1), the register readback.
REQ-008 SHALL have CPU bus pass-through inputs `cpu_address[31:2]`, `cpu_data_out` (32), `cpu_data_strobes` (4), `cpu_read` and `cpu_write`.
REQ-009 SHALL have shared-bus outputs `bus_address[31:2]`, `bus_data_out` (32), `bus_data_strobes` (4), `bus_read` and `bus_write`.
REQ-010 SHALL have input `bus_data_in` (32), the read data returned from the memories.
REQ-011 SHALL have output `cpu_hold` (1); while it is high the CPU is stalled and the engine owns the shared bus.

Function
REQ-012 SHALL hold the registers SRC[31:2], DST[31:2] and COUNT[COUNT_WIDTH-1:0]; a write with the matching cs loads them from data_in[31:2] or data_in[COUNT_WIDTH-1:0].
REQ-013 SHALL ignore writes to SRC, DST and COUNT while busy.
REQ-014 SHALL treat a control write as follows:
- bit0 = start;
- bit1 = abort;
- start while busy is ignored;
- abort while idle is ignored;
- start and abort together while idle means start only.
REQ-015 SHALL return on a control read data_out = {29'b0, aborted, done, busy}.
REQ-016 SHALL return on an SRC, DST or COUNT read the current register value, zero-extended, with address registers at bits [31:2] and bits [1:0] = 0.
REQ-017 SHALL drive data_out_valid = read & (src_cs | dst_cs | count_cs | control_cs), combinationally; when it is 0, data_out SHALL be 0.
REQ-018 SHALL sequence through the states IDLE, REQUEST, READ, CAPTURE and WRITE.
REQ-019 SHALL move from IDLE to REQUEST on start when COUNT != 0, and clear done and aborted at the same time.
REQ-020 SHALL, on start with COUNT == 0, stay in IDLE, set done and clear aborted; cpu_hold never asserts.
REQ-021 SHALL spend REQUEST as one cycle with cpu_hold = 1 and bus_read = bus_write = 0, so the CPU's in-flight cycle retires, then go to READ.
REQ-022 SHALL drive in READ: bus_address = SRC, bus_read = 1, bus_data_strobes = 4'b1111; next state is CAPTURE.
REQ-023 SHALL keep the bus idle in CAPTURE and latch bus_data_in into an internal word buffer at the cycle end; next state is WRITE.
REQ-024 SHALL drive in WRITE: bus_address = DST, bus_data_out = buffer, bus_write = 1, bus_data_strobes = 4'b1111.
REQ-025 SHALL, at the end of each WRITE cycle:
- increment SRC and DST by one word, modulo 2^30;
- decrement COUNT;
- if the new COUNT == 0, go to IDLE and set done;
- otherwise go to READ.
REQ-026 SHALL make abort take effect at the next WRITE completion:
- the in-flight word completes and is counted;
- the engine goes to IDLE and sets aborted;
- done stays 0;
- the remaining count is left readable in COUNT.
REQ-027 SHALL, if completion and a pending abort coincide, go to IDLE with done = 1 and aborted = 0.
REQ-028 SHALL define busy = (state != IDLE) and cpu_hold = busy.
REQ-029 SHALL, while cpu_hold = 0, drive all bus_* outputs combinationally from the matching cpu_* inputs.
REQ-030 SHALL, while cpu_hold = 1, drive the bus from the engine and ignore the cpu_* inputs.
REQ-031 SHALL have a per-word cost of exactly 3 cycles; a transfer of N words SHALL hold the bus for 1 + 3N cycles.
REQ-032 SHALL keep done and aborted sticky until the next accepted start or reset.

Reset
REQ-033 SHALL, on reset, set state = IDLE and SRC = DST = COUNT = 0, clear busy, done, aborted and the buffer, and drop cpu_hold in the cycle after the reset edge.
REQ-034 SHALL make reset mid-transfer abandon the transfer without any further bus_write, and SHALL give reset priority over every register write.

Verification
REQ-035 Bench SHALL run this copy case:
- stimulus: SRC = 0x00000100, DST = 0x01000000, COUNT = 2; start sampled at edge N.
- response: cpu_hold high for cycles N+1..N+7;
- bus_read at 0x100 (N+2) and 0x104 (N+5);
- bus_write at 0x01000000 (N+4) and 0x01000004 (N+7);
- control reads 0x2 afterwards.
REQ-036 Bench SHALL run this zero-count case:
- stimulus: COUNT = 0, start.
- response: no cpu_hold and control reads 0x2.
REQ-037 Bench SHALL run this abort case:
- stimulus: COUNT = 5; abort written during the second READ.
- response: exactly 2 bus_writes; control reads 0x4; COUNT reads 3.
REQ-038 Bench SHALL run this wrap case:
- stimulus: SRC[31:2] = 0x3FFFFFFF, COUNT = 2.
- response: the second read is at bus_address 0.
REQ-039 Bench SHALL run this busy-write case:
- stimulus: while busy, write SRC = 0x200 and start again.
- response: SRC and the transfer are unaffected and the transfer completes normally.
REQ-040 Bench SHALL run this reset case:
- stimulus: reset asserted in CAPTURE of word 1.
- response: cpu_hold = 0 next cycle, no bus_write occurs, and all registers read 0.
